// File: rtl/prio_enc_pkg.sv
// Shared constants, FSM state type and helpers for the 74148-style
// priority encoder with a sticky pending register and valid/ready handshake.
package prio_enc_pkg;

  localparam int N_REQ  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  // One-hot mask for an encoded request index.
  function automatic logic [N_REQ-1:0] code_to_onehot(input logic [CODE_W-1:0] code);
    logic [N_REQ-1:0] mask;
    mask       = {N_REQ{1'b0}};
    mask[code] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/prio_enc_find.sv
// Combinational highest-set-bit search: index of the most significant
// set bit plus an any-set flag.
module prio_enc_find
  import prio_enc_pkg::*;
(
  input  logic [N_REQ-1:0]  vec,
  output logic [CODE_W-1:0] idx,
  output logic              any
);

  // Ascending scan so the highest set bit is the last assignment to win.
  always_comb begin
    idx = {CODE_W{1'b0}};
    any = |vec;
    for (int i = 0; i < N_REQ; i++) begin
      if (vec[i]) begin
        idx = CODE_W'(i);
      end else begin
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/prio_enc_74148.sv
// 74148-compatible priority encoder front end: captures active-low
// requests into a pending register and offers one code at a time.
module prio_enc_74148
  import prio_enc_pkg::*;
#(
  parameter int STICKY = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              ei_n_i,
  input  logic [N_REQ-1:0]  in_n_i,
  input  logic              clear_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [CODE_W-1:0] code_o,
  output logic [CODE_W-1:0] a_n_o,
  output logic              gs_n_o,
  output logic              eo_n_o,
  output logic [N_REQ-1:0]  pending_o
);

  state_e             state_r;
  state_e             state_nxt_s;
  logic [N_REQ-1:0]   pending_r;
  logic [N_REQ-1:0]   pending_nxt_s;
  logic [CODE_W-1:0]  code_r;
  logic [CODE_W-1:0]  code_nxt_s;
  logic               eo_n_r;
  logic               eo_n_nxt_s;
  logic [N_REQ-1:0]   req_s;
  logic [N_REQ-1:0]   served_s;
  logic               hs_s;
  logic [CODE_W-1:0]  find_idx_s;
  logic               find_any_s;

  prio_enc_find u_find (
    .vec (pending_r),
    .idx (find_idx_s),
    .any (find_any_s)
  );

  // Request gating, handshake detection and served-bit mask.
  always_comb begin
    req_s    = ei_n_i ? {N_REQ{1'b0}} : ~in_n_i;
    hs_s     = (state_r == OFFER) && ready_i && !clear_i;
    served_s = hs_s ? code_to_onehot(code_r) : {N_REQ{1'b0}};
  end

  // Pending update: clear beats set, set beats served on the same bit.
  always_comb begin
    pending_nxt_s = pending_r;
    if (clear_i) begin
      pending_nxt_s = {N_REQ{1'b0}};
    end else if (STICKY != 0) begin
      pending_nxt_s = (pending_r & ~served_s) | req_s;
    end else begin
      pending_nxt_s = req_s;
    end
  end

  // FSM next state; the code is latched only when leaving IDLE so later
  // higher-priority arrivals cannot preempt an offer in flight.
  always_comb begin
    state_nxt_s = state_r;
    code_nxt_s  = code_r;
    case (state_r)
      IDLE: begin
        if (find_any_s && !clear_i) begin
          state_nxt_s = OFFER;
          code_nxt_s  = find_idx_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      OFFER: begin
        if (clear_i || ready_i) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = OFFER;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        code_nxt_s  = {CODE_W{1'b0}};
      end
    endcase
  end

  // Enable-out: low only when enabled, idle and nothing requested or pending.
  always_comb begin
    if (!ei_n_i && (in_n_i == {N_REQ{1'b1}}) && (pending_r == {N_REQ{1'b0}})
        && (state_r == IDLE)) begin
      eo_n_nxt_s = 1'b0;
    end else begin
      eo_n_nxt_s = 1'b1;
    end
  end

  // State, pending, code and enable-out registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r   <= IDLE;
      pending_r <= {N_REQ{1'b0}};
      code_r    <= {CODE_W{1'b0}};
      eo_n_r    <= 1'b1;
    end else begin
      state_r   <= state_nxt_s;
      pending_r <= pending_nxt_s;
      code_r    <= code_nxt_s;
      eo_n_r    <= eo_n_nxt_s;
    end
  end

  assign valid_o   = (state_r == OFFER);
  assign code_o    = valid_o ? code_r : {CODE_W{1'b0}};
  assign a_n_o     = valid_o ? ~code_r : {CODE_W{1'b1}};
  assign gs_n_o    = ~valid_o;
  assign eo_n_o    = eo_n_r;
  assign pending_o = pending_r;

endmodule

// File: tb/tb_prio_enc_74148.sv
// Scoreboard bench: directed vectors push expected handshake codes; a
// negedge monitor pops and compares on every accepted offer.
module tb_prio_enc_74148;

  logic       clk;
  logic       rst_n;
  logic       ei_n;
  logic [7:0] in_n;
  logic       clear;
  logic       ready;
  logic       valid;
  logic [2:0] code;
  logic [2:0] a_n;
  logic       gs_n;
  logic       eo_n;
  logic [7:0] pending;

  logic       ready_ns;
  logic       valid_ns;
  logic [2:0] code_ns;
  logic [2:0] a_n_ns;
  logic       gs_n_ns;
  logic       eo_n_ns;
  logic [7:0] pending_ns;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2:0] exp_q[$];

  prio_enc_74148 #(.STICKY(1)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .ei_n_i(ei_n), .in_n_i(in_n),
    .clear_i(clear), .ready_i(ready), .valid_o(valid), .code_o(code),
    .a_n_o(a_n), .gs_n_o(gs_n), .eo_n_o(eo_n), .pending_o(pending)
  );

  prio_enc_74148 #(.STICKY(0)) u_dut_ns (
    .clk_i(clk), .rst_n_i(rst_n), .ei_n_i(ei_n), .in_n_i(in_n),
    .clear_i(clear), .ready_i(ready_ns), .valid_o(valid_ns), .code_o(code_ns),
    .a_n_o(a_n_ns), .gs_n_o(gs_n_ns), .eo_n_o(eo_n_ns), .pending_o(pending_ns)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_offer(input string name, input logic v, input logic [2:0] c);
    chk({name, "_valid"}, {31'd0, valid}, {31'd0, v});
    chk({name, "_code"}, {29'd0, code}, {29'd0, v ? c : 3'd0});
    chk({name, "_a_n"}, {29'd0, a_n}, {29'd0, v ? ~c : 3'b111});
    chk({name, "_gs_n"}, {31'd0, gs_n}, {31'd0, ~v});
  endtask

  // Monitor: a handshake is about to be taken at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && valid && ready && !clear) begin
      chk("hs_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        logic [2:0] e;
        e = exp_q.pop_front();
        chk("hs_code", {29'd0, code}, {29'd0, e});
        chk("hs_a_n", {29'd0, a_n}, {29'd0, ~e});
      end
    end
  end

  initial begin
    logic [7:0] vecs [5];
    vecs = '{8'hFE, 8'h5A, 8'hFF, 8'h00, 8'hC3};
    rst_n = 1'b0; ei_n = 1'b0; in_n = 8'hFF; clear = 1'b0; ready = 1'b0; ready_ns = 1'b0;

    // Reset state
    #12;
    chk_offer("rst", 1'b0, 3'd0);
    chk("rst_eo_n", {31'd0, eo_n}, 32'd1);
    chk("rst_pending", {24'd0, pending}, 32'h00);
    rst_n = 1'b1;

    // Idle with enable and no requests: eo_n low from first edge
    for (int i = 0; i < 3; i++) begin
      step();
      chk_offer("idle", 1'b0, 3'd0);
      chk("idle_eo_n", {31'd0, eo_n}, 32'd0);
    end

    // Two simultaneous requests served in priority order
    ready = 1'b1; in_n = 8'b1101_0111;
    exp_q.push_back(3'd5); exp_q.push_back(3'd3);
    step(); in_n = 8'hFF;
    chk("two_pend0", {24'd0, pending}, 32'h28);
    chk_offer("two_c0", 1'b0, 3'd0);
    chk("two_eo_n", {31'd0, eo_n}, 32'd1);
    step(); chk_offer("two_c1", 1'b1, 3'd5); chk("two_pend1", {24'd0, pending}, 32'h28);
    step(); chk_offer("two_c2", 1'b0, 3'd0); chk("two_pend2", {24'd0, pending}, 32'h08);
    step(); chk_offer("two_c3", 1'b1, 3'd3);
    step(); chk_offer("two_c4", 1'b0, 3'd0); chk("two_pend4", {24'd0, pending}, 32'h00);

    // Offer held under backpressure, no preemption by bit 6
    ready = 1'b0; in_n = 8'b1111_1011;
    exp_q.push_back(3'd2); exp_q.push_back(3'd6);
    step(); in_n = 8'hFF; chk("bp_pend0", {24'd0, pending}, 32'h04);
    step(); chk_offer("bp_c1", 1'b1, 3'd2); in_n = 8'b1011_1111;
    step(); chk_offer("bp_c2", 1'b1, 3'd2); in_n = 8'hFF;
    step(); chk_offer("bp_c3", 1'b1, 3'd2); chk("bp_pend3", {24'd0, pending}, 32'h44);
    step(); chk_offer("bp_c4", 1'b1, 3'd2); ready = 1'b1;
    step(); chk_offer("bp_c5", 1'b0, 3'd0); chk("bp_pend5", {24'd0, pending}, 32'h40);
    step(); chk_offer("bp_c6", 1'b1, 3'd6);
    step(); chk_offer("bp_c7", 1'b0, 3'd0); chk("bp_pend7", {24'd0, pending}, 32'h00);
    ready = 1'b0;

    // Clear with ready during an offer: no handshake, pending flushed
    in_n = 8'b1111_1110;
    step(); in_n = 8'hFF; chk("clr_pend0", {24'd0, pending}, 32'h01);
    step(); chk_offer("clr_c1", 1'b1, 3'd0); clear = 1'b1; ready = 1'b1;
    step(); clear = 1'b0; ready = 1'b0;
    chk_offer("clr_c2", 1'b0, 3'd0); chk("clr_pend2", {24'd0, pending}, 32'h00);
    step(); chk_offer("clr_c3", 1'b0, 3'd0); chk("clr_pend3", {24'd0, pending}, 32'h00);

    // Disabled input: nothing captured; re-enable drains all eight codes
    ei_n = 1'b1; in_n = 8'h00;
    step(); chk("dis_pend0", {24'd0, pending}, 32'h00); chk("dis_eo0", {31'd0, eo_n}, 32'd1);
    step(); chk("dis_pend1", {24'd0, pending}, 32'h00); chk("dis_eo1", {31'd0, eo_n}, 32'd1);
    ei_n = 1'b0;
    for (int k = 7; k >= 0; k--) exp_q.push_back(3'(k));
    step(); chk("en_pend", {24'd0, pending}, 32'hFF); chk_offer("en_c1", 1'b0, 3'd0);
    step(); chk_offer("en_c2", 1'b1, 3'd7);
    in_n = 8'hFF; ready = 1'b1;
    for (int i = 0; i < 15; i++) step();
    chk_offer("drain_end", 1'b0, 3'd0); chk("drain_pend", {24'd0, pending}, 32'h00);
    ready = 1'b0;

    // Asynchronous reset mid-offer
    in_n = 8'b0111_1111;
    step(); in_n = 8'hFF;
    step(); chk_offer("ar_c1", 1'b1, 3'd7);
    #2 rst_n = 1'b0;
    #1 chk_offer("ar_now", 1'b0, 3'd0); chk("ar_pend", {24'd0, pending}, 32'h00);
    @(negedge clk) rst_n = 1'b1;
    step(); chk_offer("ar_after", 1'b0, 3'd0); chk("ar_pend_after", {24'd0, pending}, 32'h00);

    // Non-sticky instance follows the inputs with one cycle lag
    foreach (vecs[i]) begin
      in_n = vecs[i];
      step();
      chk("ns_track", {24'd0, pending_ns}, {24'd0, ~vecs[i]});
    end
    in_n = 8'h00; clear = 1'b1;
    step(); chk("ns_clear", {24'd0, pending_ns}, 32'h00);
    clear = 1'b0; in_n = 8'hFF;

    @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prio_enc_74148.md
PRIO_ENC_74148 -- requirements
Module: prio_enc_74148

Interface
REQ-001 The module SHALL have parameter STICKY, default 1; 1 = captured requests are held until served or cleared, 0 = the pending register follows the live inputs every cycle.
REQ-002 The module SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n_i, input, 1, reset; asynchronous, active-low.
REQ-004 The module SHALL have port ei_n_i, input, 1, capture enable, active-low.
REQ-005 The module SHALL have port in_n_i, input, 8, request lines, active-low; bit 7 has highest priority.
REQ-006 The module SHALL have port clear_i, input, 1, synchronous flush of all pending requests.
REQ-007 The module SHALL have port ready_i, input, 1, consumer accepts the offered code.
REQ-008 The module SHALL have port valid_o, output, 1, a code is being offered.
REQ-009 The module SHALL have port code_o, output, 3, offered index, active-high.
REQ-010 The module SHALL have port a_n_o, output, 3, offered index, active-low (74148-compatible).
REQ-011 The module SHALL have port gs_n_o, output, 1, group select, active-low, equal to ~valid_o.
REQ-012 The module SHALL have port eo_n_o, output, 1, enable out, active-low, registered.
REQ-013 The module SHALL have port pending_o, output, 8, current pending register, active-high.

Function
REQ-014 The request vector SHALL be req = ~in_n_i, gated to zero whenever ei_n_i = 1.
REQ-015 With STICKY=1, pending SHALL be updated as follows: clear_i=1 -> 0; otherwise (pending & ~served) | req.
- served = one-hot of code_o on a handshake cycle, else 0.
- Set wins over served for the same bit; clear_i wins over set.
REQ-016 With STICKY=0, pending SHALL be updated as follows: clear_i=1 -> 0; otherwise req. There is no served masking.
REQ-017 The FSM SHALL have states IDLE and OFFER.
- IDLE with pending != 0 -> OFFER next edge; code_q captures the highest set index of pending.
REQ-018 In OFFER, valid_o SHALL be 1 and code_o SHALL equal code_q, held stable until handshake.
- Higher-priority arrivals SHALL NOT preempt the offered code.
- ei_n_i SHALL NOT gate the handshake.
REQ-019 A handshake SHALL be valid_o=1 and ready_i=1 at a rising edge.
- On handshake the FSM returns to IDLE.
- Minimum spacing between consecutive offers is 2 cycles.
REQ-020 clear_i=1 in OFFER SHALL force IDLE and drop valid_o on the next edge; simultaneous ready_i counts as no handshake.
REQ-021 Latency SHALL be: request low at edge N -> in pending after edge N -> valid_o high after edge N+1.
REQ-022 In IDLE, valid_o SHALL be 0 and code_o 0.
REQ-023 a_n_o SHALL equal ~code_o when valid_o=1, else 3'b111.
REQ-024 eo_n_o SHALL be registered each edge as 0 iff ei_n_i=0 and in_n_i=8'hFF and pending=0 and state=IDLE; otherwise 1.
REQ-025 pending_o SHALL equal the pending register.

Reset
REQ-026 While rst_n_i=0, the module SHALL hold: state IDLE, pending 0, code_q 0, eo_n_o 1; hence valid_o 0, code_o 0, a_n_o 111, gs_n_o 1.
REQ-027 Reset asserted mid-OFFER SHALL drop valid_o immediately (asynchronously) without handshake; the offered request is discarded.
REQ-028 After reset release, the first capture SHALL occur on the first rising edge with rst_n_i=1.

Structure
REQ-029 Package prio_enc_pkg SHALL hold:
- constants N_REQ=8 and CODE_W=3;
- the state enum (IDLE, OFFER).
REQ-030 The highest-set-bit search SHALL be a combinational sub-module prio_enc_find: 8-bit vector in, 3-bit index plus any-flag out.
REQ-031 Total RTL SHALL be 120-400 lines.

Verification
REQ-032 Reset then ei_n_i=0, in_n_i=8'hFF for 3 cycles -> valid_o=0, a_n_o=111, gs_n_o=1, eo_n_o=0 from the first post-reset edge.
REQ-033 in_n_i=8'b1101_0111 for 1 cycle, ready_i=1 (STICKY=1) -> offers code 5, then code 3, each held 1 cycle, 2 cycles apart; pending_o goes 8'h28 -> 8'h08 -> 0.
REQ-034 Offer of code 2 with ready_i=0, then in_n_i[6]=0 pulse -> code_o stays 2 until ready_i=1; code 6 is offered next.
REQ-035 clear_i=1 and ready_i=1 in the same cycle during OFFER -> valid_o=0 next cycle, pending_o=0, no handshake counted.
REQ-036 ei_n_i=1 with in_n_i=8'h00 -> pending_o stays 0, eo_n_o=1; ei_n_i=0 -> code 7 offered 2 edges later.
REQ-037 rst_n_i pulsed low while valid_o=1 -> valid_o=0 immediately, pending_o=0; STICKY=0 run -> pending_o tracks ~in_n_i with a 1-cycle lag.
